ps2_rx: RTL and testbench
=========================

PS2_RX -- requirements
Module: ps2_rx

Interface
REQ-001 Parameter FILTER_LEN, default 8: clock glitch-filter depth in cycles.
REQ-002 Parameter TIMEOUT_CYCLES, default 20000: max cycles allowed between falling edges inside a frame.
REQ-003 clk_i  input  1  system clock; the only clock.
REQ-004 reset_i  input  1  reset; synchronous and active-high.
REQ-005 rx_en_i  input  1  receive enable; top level drives it low while the host transmitter owns the bus.
REQ-006 ps2c_i  input  1  PS/2 clock line, asynchronous, read-only (tristate handled at top level).
REQ-007 ps2d_i  input  1  PS/2 data line, asynchronous, read-only.
REQ-008 rx_data_o  output  8  last correctly received byte.
REQ-009 rx_done_o  output  1  one-cycle pulse: rx_data_o updated with a valid frame.
REQ-010 parity_err_o  output  1  one-cycle pulse: frame discarded, odd parity failed.
REQ-011 frame_err_o  output  1  one-cycle pulse: frame discarded, stop bit was 0.
REQ-012 timeout_o  output  1  one-cycle pulse: frame abandoned, clock stalled.
REQ-013 idle_o  output  1  high while in IDLE.

Function
REQ-014 ps2c_i and ps2d_i SHALL each pass through a 2-flop synchronizer before any other use.
REQ-015 Filtered clock SHALL go 1 when the last FILTER_LEN synchronized ps2c samples are all 1, go 0 when all are 0, and otherwise hold.
REQ-016 falling_edge SHALL be a one-cycle strobe when filtered clock changes 1->0; synchronized ps2d is sampled in that same cycle.
REQ-017 Frame format: start(0), D0..D7 LSB first, parity, stop(1); 11 falling edges total.
REQ-018 States: IDLE, DATA, PARITY, STOP.
REQ-019 IDLE: falling_edge with sampled data 0 -> DATA with bit counter cleared; sampled data 1 -> stay in IDLE, no pulse.
REQ-020 DATA: each falling_edge shifts the sampled bit into an 8-bit shift register from the MSB end; after the 8th bit -> PARITY.
REQ-021 PARITY: falling_edge captures the parity bit -> STOP.
REQ-022 STOP: on falling_edge -> IDLE; stop bit 0 -> frame_err_o, regardless of parity.
REQ-023 STOP: on falling_edge, stop bit 1 with odd ones count over D0..D7 plus parity -> rx_data_o loaded, rx_done_o pulsed.
REQ-024 STOP: on falling_edge, stop bit 1 with even ones count over D0..D7 plus parity -> parity_err_o pulsed, rx_data_o unchanged.
REQ-025 Latency: pulses and the rx_data_o update SHALL be visible in the cycle after the stop-bit falling_edge cycle, high exactly one cycle.
REQ-026 At most one of rx_done_o, parity_err_o, frame_err_o, timeout_o SHALL be high in any cycle.
REQ-027 Timeout counter: cleared on every falling_edge and in IDLE; increments in other states.
REQ-028 On reaching TIMEOUT_CYCLES the block SHALL pulse timeout_o, discard the partial frame and enter IDLE.
REQ-029 rx_en_i low in any state SHALL force IDLE next cycle, clear counters, emit no pulse and ignore edges.
REQ-030 Filter and synchronizers SHALL keep running while rx_en_i is low, so no stale edge fires on re-enable.
REQ-031 rx_en_i low in the same cycle as a stop-bit falling_edge: disable wins, no pulse.
REQ-032 A falling_edge in the same cycle the timeout count is reached: the edge wins and the counter clears.

Reset
REQ-033 reset_i high at a clock edge SHALL set state IDLE, rx_data_o=0x00, all pulses 0, idle_o=1, counters 0.
REQ-034 Reset SHALL set the synchronizers and filter to 1 (bus idle) and the filtered clock to 1.
REQ-035 Reset mid-frame SHALL discard the partial frame with no pulse.

Verification
REQ-036 Frame 0x5A, parity 1, stop 1, 40 us bit period -> rx_done_o one pulse, rx_data_o=0x5A, no error pulses.
REQ-037 Frame 0xFA with parity 0 -> parity_err_o one pulse, rx_done_o stays 0, rx_data_o keeps prior value 0x5A.
REQ-038 Frame 0xAA (parity 1) with stop bit 0 -> frame_err_o pulse only; back-to-back next frame 0x00 (parity 1) -> rx_done_o, rx_data_o=0x00.
REQ-039 3-cycle low glitch on ps2c_i while idle, with ps2d_i=0 -> no state change, idle_o stays 1.
REQ-040 Start plus 4 data bits, then clock held high -> timeout_o pulses TIMEOUT_CYCLES cycles after the last edge; following 0x12 frame is received correctly.
REQ-041 rx_en_i dropped after bit D3, raised, then full frame 0x34 -> no pulse for the aborted frame, rx_done_o with 0x34; reset_i mid-frame -> all outputs return to REQ-033 values.

Source files
------------

// File: rtl/ps2_rx.sv
// PS/2 device-to-host frame receiver: synchronizes and deglitches the bus clock, then shifts in
// start/data/parity/stop bits and reports each frame as a good byte, parity error, frame error or timeout.
module ps2_rx #(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 20000
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       rx_en_i,
    input  logic       ps2c_i,
    input  logic       ps2d_i,
    output logic [7:0] rx_data_o,
    output logic       rx_done_o,
    output logic       parity_err_o,
    output logic       frame_err_o,
    output logic       timeout_o,
    output logic       idle_o
);

    localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

    logic                  ps2c_s1_q, ps2c_s2_q, ps2d_s1_q, ps2d_s2_q;
    logic [FILTER_LEN-1:0] filt_q, filt_d;
    logic                  fclk_q, fclk_d;
    logic                  fall;

    state_e                state_q, state_d;
    logic [2:0]            bit_cnt_q, bit_cnt_d;
    logic [7:0]            shift_q, shift_d;
    logic                  par_q, par_d;
    logic [TmoW-1:0]       tmo_cnt_q, tmo_cnt_d;
    logic [7:0]            rx_data_q, rx_data_d;
    logic                  done_q, done_d;
    logic                  perr_q, perr_d;
    logic                  ferr_q, ferr_d;
    logic                  tmo_q, tmo_d;

    // Filter keeps running regardless of rx_en_i so re-enable never sees a stale edge.
    always_comb begin
        filt_d = {filt_q[FILTER_LEN-2:0], ps2c_s2_q};
        fclk_d = fclk_q;
        if (&filt_d) begin
            fclk_d = 1'b1;
        end else if (~|filt_d) begin
            fclk_d = 1'b0;
        end
        fall = fclk_q & ~fclk_d;
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_d     = par_q;
        tmo_cnt_d = tmo_cnt_q;
        rx_data_d = rx_data_q;
        done_d    = 1'b0;
        perr_d    = 1'b0;
        ferr_d    = 1'b0;
        tmo_d     = 1'b0;

        if (!rx_en_i) begin
            state_d   = StIdle;
            bit_cnt_d = '0;
            tmo_cnt_d = '0;
        end else if (state_q == StIdle) begin
            tmo_cnt_d = '0;
            if (fall && !ps2d_s2_q) begin
                state_d   = StData;
                bit_cnt_d = '0;
            end
        end else if (fall) begin
            // An edge beats a simultaneous timeout.
            tmo_cnt_d = '0;
            unique case (state_q)
                StData: begin
                    shift_d   = {ps2d_s2_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = StParity;
                    end
                end
                StParity: begin
                    par_d   = ps2d_s2_q;
                    state_d = StStop;
                end
                StStop: begin
                    state_d = StIdle;
                    if (!ps2d_s2_q) begin
                        ferr_d = 1'b1;
                    end else if (^{shift_q, par_q}) begin
                        rx_data_d = shift_q;
                        done_d    = 1'b1;
                    end else begin
                        perr_d = 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end else if (tmo_cnt_q >= TmoW'(TIMEOUT_CYCLES - 1)) begin
            tmo_d     = 1'b1;
            tmo_cnt_d = '0;
            state_d   = StIdle;
        end else begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ps2c_s1_q <= 1'b1;
            ps2c_s2_q <= 1'b1;
            ps2d_s1_q <= 1'b1;
            ps2d_s2_q <= 1'b1;
            filt_q    <= '1;
            fclk_q    <= 1'b1;
            state_q   <= StIdle;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            tmo_cnt_q <= '0;
            rx_data_q <= '0;
            done_q    <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            tmo_q     <= 1'b0;
        end else begin
            ps2c_s1_q <= ps2c_i;
            ps2c_s2_q <= ps2c_s1_q;
            ps2d_s1_q <= ps2d_i;
            ps2d_s2_q <= ps2d_s1_q;
            filt_q    <= filt_d;
            fclk_q    <= fclk_d;
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            tmo_cnt_q <= tmo_cnt_d;
            rx_data_q <= rx_data_d;
            done_q    <= done_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
            tmo_q     <= tmo_d;
        end
    end

    assign rx_data_o    = rx_data_q;
    assign rx_done_o    = done_q;
    assign parity_err_o = perr_q;
    assign frame_err_o  = ferr_q;
    assign timeout_o    = tmo_q;
    assign idle_o       = (state_q == StIdle);

endmodule

// File: tb/tb_ps2_rx.sv
// Directed and randomized PS/2 frames against a byte-level model of expected outcomes.
module tb_ps2_rx;

    localparam int unsigned FL  = 8;
    localparam int unsigned TMO = 300;

    logic       clk = 1'b0;
    logic       reset_i, rx_en_i, ps2c_i, ps2d_i;
    logic [7:0] rx_data_o;
    logic       rx_done_o, parity_err_o, frame_err_o, timeout_o, idle_o;

    ps2_rx #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TMO)) dut (
        .clk_i        (clk),
        .reset_i      (reset_i),
        .rx_en_i      (rx_en_i),
        .ps2c_i       (ps2c_i),
        .ps2d_i       (ps2d_i),
        .rx_data_o    (rx_data_o),
        .rx_done_o    (rx_done_o),
        .parity_err_o (parity_err_o),
        .frame_err_o  (frame_err_o),
        .timeout_o    (timeout_o),
        .idle_o       (idle_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor: cumulative high-cycle counts and the cycle of the most recent pulse.
    int n_done = 0, n_perr = 0, n_ferr = 0, n_tmo = 0, n_excl = 0, n_busy = 0;
    int done_cyc = 0, tmo_cyc = 0;
    always @(negedge clk) begin
        if (!reset_i) begin
            if (rx_done_o)    begin n_done++; done_cyc = cyc; end
            if (parity_err_o) n_perr++;
            if (frame_err_o)  n_ferr++;
            if (timeout_o)    begin n_tmo++; tmo_cyc = cyc; end
            if (int'(rx_done_o) + int'(parity_err_o) + int'(frame_err_o) + int'(timeout_o) > 1)
                n_excl++;
            if (!idle_o) n_busy++;
        end
    end

    int checks = 0, errors = 0;
    int exp_done = 0, exp_perr = 0, exp_ferr = 0, exp_tmo = 0;
    logic [7:0] exp_data = 8'h00;
    int half = 25;
    int last_fall = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic odd_par(input logic [7:0] b);
        int ones = 0;
        for (int i = 0; i < 8; i++) if (b[i]) ones++;
        return (ones % 2 == 0) ? 1'b1 : 1'b0;
    endfunction

    // Drive the first n bits of a frame (bit 0 = start) with the current half period.
    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            ps2d_i = bits[i];
            idle_cycles(half);
            ps2c_i    = 1'b0;
            last_fall = cyc;
            idle_cycles(half);
            ps2c_i = 1'b1;
        end
        ps2d_i = 1'b1;
    endtask

    // Send a full frame and update the model according to its parity/stop content.
    task automatic frame(input logic [7:0] b, input logic par, input logic stop);
        send_bits({stop, par, b, 1'b0}, 11);
        idle_cycles(20);
        if (!stop) exp_ferr++;
        else if (par == odd_par(b)) begin exp_done++; exp_data = b; end
        else exp_perr++;
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_done"}, n_done, exp_done);
        chk({tag, "_perr"}, n_perr, exp_perr);
        chk({tag, "_ferr"}, n_ferr, exp_ferr);
        chk({tag, "_tmo"}, n_tmo, exp_tmo);
        chk({tag, "_data"}, rx_data_o, exp_data);
        chk({tag, "_idle"}, idle_o, 1'b1);
        chk({tag, "_excl"}, n_excl, 0);
    endtask

    initial begin
        int busy0, lat, kind;
        logic [7:0] b;
        reset_i = 1'b1; rx_en_i = 1'b1; ps2c_i = 1'b1; ps2d_i = 1'b1;
        idle_cycles(3);
        chk("rst_data", rx_data_o, 8'h00);
        chk("rst_pulses", {rx_done_o, parity_err_o, frame_err_o, timeout_o}, 4'b0000);
        chk("rst_idle", idle_o, 1'b1);
        reset_i = 1'b0;
        idle_cycles(20);

        frame(8'h5A, 1'b1, 1'b1);
        check_all("f5a");
        lat = done_cyc - last_fall;
        chk("done_latency", (lat >= int'(FL) && lat <= int'(FL) + 4), 1'b1);

        frame(8'hFA, 1'b0, 1'b1);
        check_all("fa_par");
        frame(8'hAA, 1'b1, 1'b0);
        check_all("aa_stop");
        frame(8'h00, 1'b1, 1'b1);
        check_all("b2b_00");

        // Short low glitch on the clock line must not start a frame.
        busy0 = n_busy;
        ps2d_i = 1'b0; ps2c_i = 1'b0;
        idle_cycles(3);
        ps2c_i = 1'b1;
        idle_cycles(30);
        ps2d_i = 1'b1;
        chk("glitch_busy", n_busy - busy0, 0);
        check_all("glitch");

        // Stalled clock after start + 4 data bits.
        send_bits({1'b1, 1'b1, 8'h0F, 1'b0}, 5);
        idle_cycles(TMO + 40);
        exp_tmo++;
        check_all("tmo");
        lat = tmo_cyc - last_fall;
        chk("tmo_latency", (lat >= int'(TMO + FL) && lat <= int'(TMO + FL) + 4), 1'b1);
        frame(8'h12, 1'b1, 1'b1);
        check_all("after_tmo");

        // Disable after D3, keep clocking while disabled, then re-enable.
        send_bits({1'b1, 1'b1, 8'hC5, 1'b0}, 5);
        rx_en_i = 1'b0;
        send_bits({1'b1, 1'b0, 8'h00, 1'b0}, 4);
        idle_cycles(20);
        rx_en_i = 1'b1;
        idle_cycles(20);
        frame(8'h34, 1'b0, 1'b1);
        check_all("en_abort");

        // Randomized frames with random corruption.
        for (int i = 0; i < 8; i++) begin
            b    = 8'($urandom);
            half = int'($urandom_range(20, 40));
            kind = int'($urandom_range(0, 3));
            case (kind)
                2:       frame(b, ~odd_par(b), 1'b1);
                3:       frame(b, odd_par(b), 1'b0);
                default: frame(b, odd_par(b), 1'b1);
            endcase
            check_all("rand");
        end
        half = 25;

        // Reset mid-frame returns everything to reset values with no pulse.
        send_bits({1'b1, 1'b1, 8'h77, 1'b0}, 6);
        reset_i = 1'b1;
        idle_cycles(2);
        chk("mrst_data", rx_data_o, 8'h00);
        chk("mrst_pulses", {rx_done_o, parity_err_o, frame_err_o, timeout_o}, 4'b0000);
        chk("mrst_idle", idle_o, 1'b1);
        reset_i  = 1'b0;
        exp_data = 8'h00;
        idle_cycles(20);
        check_all("mrst");
        frame(8'hC3, 1'b1, 1'b1);
        check_all("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
